// File: rtl/dr_link_rx.sv
// dr_link_rx - clocked receiver for a dual-rail asynchronous link.
//
// Every rail goes through its own synchroniser into the clk domain. The
// synchronised word is decoded and must stay complete, with an unchanged
// value, for STABLE_CYCLES cycles before it is captured. Captured words are
// acknowledged back to the sender and queued in a small FIFO.
//
// Encodings (ENC):
//   "TP"  two-phase transition dual-rail; ack_o toggles once per word.
//   "FP"  four-phase return-to-zero dual-rail; ack_o rises on capture and
//         falls after the null word has held for STABLE_CYCLES cycles.
//
// Optional build macro: DR_LINK_RX_ERR_CHK_EN enables the encoding checker
// that drives err_o. Without it err_o is tied 0.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   in       dual-rail data [bit][rail]; rail 1 = logic 1, rail 0 = logic 0
//   ack_o    registered acknowledge to the sender
//   data_o   FIFO head word
//   valid_o  FIFO non-empty
//   ready_i  consumer takes data_o when valid_o && ready_i
//   level_o  FIFO occupancy
//   err_o    sticky encoding error
//
// FSM states:
//   state     | meaning
//   IDLE      | waiting for a complete word
//   SETTLE    | complete word seen, checking it holds (also FIFO backpressure)
//   CAPTURE   | push decoded word, raise or toggle ack
//   WAIT_NULL | four-phase only: waiting for the null word before dropping ack
module dr_link_rx #(
  parameter        ENC           = "TP",
  parameter int    WIDTH         = 32,
  parameter int    SYNC_STAGES   = 2,
  parameter int    STABLE_CYCLES = 2,
  parameter int    DEPTH         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0][1:0]  in,
  output logic                   ack_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   err_o
);

  localparam bit IS_FP = (ENC == "FP");
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(STABLE_CYCLES + 1) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_NULL} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        val_q, val_d;
  logic                    ack_q, ack_d;
  logic [WIDTH-1:0][1:0]   ref_q, ref_d;
  logic                    push;

  logic [WIDTH-1:0][1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0][1:0]   s;
  logic [WIDTH-1:0][1:0]   d_w;
  logic [WIDTH-1:0]        bit_ok, dec;
  logic                    word_ok, any_active, hold_q;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [AW:0]             level_q;
  logic                    full, pop, push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // TP compares against the rails seen at the last capture; FP uses levels.
  assign d_w = IS_FP ? s : (s ^ ref_q);

  always_comb begin
    bit_ok     = '0;
    dec        = '0;
    any_active = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i]     = d_w[i][1];
      any_active = any_active | (|d_w[i]);
`ifdef DR_LINK_RX_ERR_CHK_EN
      bit_ok[i]  = d_w[i][1] ^ d_w[i][0];
`else
      // Without the checker an FP bit with both rails high decodes as 1.
      bit_ok[i]  = IS_FP ? (|d_w[i]) : (d_w[i][1] ^ d_w[i][0]);
`endif
    end
  end

  assign word_ok = &bit_ok;

`ifdef DR_LINK_RX_ERR_CHK_EN
  logic [WIDTH-1:0] illegal;
  logic [CW-1:0]    ill_cnt_q;
  logic             err_q, err_now;

  always_comb begin
    illegal = '0;
    for (int i = 0; i < WIDTH; i++) illegal[i] = &d_w[i];
  end

  // FP must see the illegal pattern on consecutive cycles; a TP double
  // transition is wrong the moment it appears.
  assign err_now = IS_FP ? ((|illegal) && (ill_cnt_q >= CNT_LAST)) : (|illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_q <= '0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      if (|illegal) begin
        if (ill_cnt_q < CNT_LAST) ill_cnt_q <= ill_cnt_q + CW'(1);
      end else begin
        ill_cnt_q <= '0;
      end
      if (err_now) begin
        err_q  <= 1'b1;
        hold_q <= 1'b1;
      end else if (!any_active) begin
        hold_q <= 1'b0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign hold_q = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      ack_q   <= 1'b0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ack_q   <= ack_d;
      ref_q   <= ref_d;
    end
  end

  // The IDLE cycle that first sees a complete word counts as stable cycle 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    ack_d   = ack_q;
    ref_d   = ref_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (word_ok && !hold_q) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
          val_d   = dec;
        end
      end
      SETTLE: begin
        if (!word_ok || hold_q) begin
          state_d = IDLE;
        end else if (dec != val_q) begin
          cnt_d = CW'(1);
          val_d = dec;
        end else if (cnt_q >= CNT_LAST) begin
          if (!full) state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        push = 1'b1;
        if (IS_FP) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_NULL;
        end else begin
          ref_d   = s;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      WAIT_NULL: begin
        if (any_active) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_o = ack_q;

  assign full    = (level_q == LVL_FULL);
  assign pop     = ready_i && (level_q != '0);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= val_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

endmodule

// File: tb/tb_dr_link_rx.sv
module tb_dr_link_rx;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0][1:0] tp_in = '0;
  logic [7:0][1:0] fp_in = '0;
  logic            tp_ready = 1'b0;
  logic            fp_ready = 1'b0;

  logic            tp_ack, tp_valid, tp_err;
  logic [7:0]      tp_data;
  logic [2:0]      tp_level;
  logic            fp_ack, fp_valid, fp_err;
  logic [7:0]      fp_data;
  logic [2:0]      fp_level;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_tp[$];
  logic [7:0] exp_fp[$];

  always #5 clk = ~clk;

  dr_link_rx #(.ENC("TP"), .WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(2), .DEPTH(4)) u_tp (
    .clk(clk), .rst_n(rst_n), .in(tp_in), .ack_o(tp_ack), .data_o(tp_data),
    .valid_o(tp_valid), .ready_i(tp_ready), .level_o(tp_level), .err_o(tp_err)
  );

  dr_link_rx #(.ENC("FP"), .WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(2), .DEPTH(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .in(fp_in), .ack_o(fp_ack), .data_o(fp_data),
    .valid_o(fp_valid), .ready_i(fp_ready), .level_o(fp_level), .err_o(fp_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Two-phase sender: toggle the rail that carries each selected bit's value.
  task automatic tp_drive(input logic [7:0] v, input logic [7:0] mask);
    for (int i = 0; i < 8; i++)
      if (mask[i]) tp_in[i][v[i]] = ~tp_in[i][v[i]];
  endtask

  task automatic tp_send(input logic [7:0] v);
    @(negedge clk);
    tp_drive(v, 8'hFF);
    exp_tp.push_back(v);
  endtask

  task automatic fp_send(input logic [7:0] v);
    @(negedge clk);
    for (int i = 0; i < 8; i++) fp_in[i] = v[i] ? 2'b10 : 2'b01;
    exp_fp.push_back(v);
  endtask

  task automatic wait_ack_tp(input logic e, input string name);
    int t;
    t = 0;
    while (tp_ack !== e && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (tp_ack !== e) begin
      miscompares++;
      $display("FAIL %s: tp ack_o=%b expected %b (timeout)", name, tp_ack, e);
    end
  endtask

  task automatic wait_ack_fp(input logic e, input string name);
    int t;
    t = 0;
    while (fp_ack !== e && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (fp_ack !== e) begin
      miscompares++;
      $display("FAIL %s: fp ack_o=%b expected %b (timeout)", name, fp_ack, e);
    end
  endtask

  task automatic drain_tp(input int n);
    logic [7:0] e;
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!tp_valid && t < 40) begin @(negedge clk); t++; end
      e = (exp_tp.size() != 0) ? exp_tp.pop_front() : 8'hxx;
      vectors++;
      if (tp_valid !== 1'b1 || tp_data !== e) begin
        miscompares++;
        $display("FAIL tp_pop: valid_o=%b data_o=%h expected valid 1 data %h", tp_valid, tp_data, e);
      end
      tp_ready = 1'b1;
      @(negedge clk);
      tp_ready = 1'b0;
    end
  endtask

  task automatic drain_fp(input int n);
    logic [7:0] e;
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!fp_valid && t < 40) begin @(negedge clk); t++; end
      e = (exp_fp.size() != 0) ? exp_fp.pop_front() : 8'hxx;
      vectors++;
      if (fp_valid !== 1'b1 || fp_data !== e) begin
        miscompares++;
        $display("FAIL fp_pop: valid_o=%b data_o=%h expected valid 1 data %h", fp_valid, fp_data, e);
      end
      fp_ready = 1'b1;
      @(negedge clk);
      fp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({tp_ack, tp_valid, tp_level, tp_data, tp_err} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_tp: ack=%b valid=%b level=%0d data=%h err=%b expected all 0",
               tp_ack, tp_valid, tp_level, tp_data, tp_err);
    end
    vectors++;
    if ({fp_ack, fp_valid, fp_level, fp_data, fp_err} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_fp: ack=%b valid=%b level=%0d data=%h err=%b expected all 0",
               fp_ack, fp_valid, fp_level, fp_data, fp_err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tp_basic;
    @(negedge clk);
    tp_drive(8'hA5, 8'hFF);
    exp_tp.push_back(8'hA5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        vectors++;
        if (tp_valid !== 1'b0 || tp_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL tp_latency_early: valid=%b ack=%b expected 0 0", tp_valid, tp_ack);
        end
      end
      if (c == 5) begin
        vectors++;
        if (tp_valid !== 1'b1 || tp_ack !== 1'b1 || tp_level !== 3'd1) begin
          miscompares++;
          $display("FAIL tp_latency: valid=%b ack=%b level=%0d expected 1 1 1", tp_valid, tp_ack, tp_level);
        end
      end
    end
    drain_tp(1);
    tp_send(8'h3C);
    wait_ack_tp(1'b0, "tp_ack_second");
    drain_tp(1);
    repeat (8) @(negedge clk);
    vectors++;
    if (tp_ack !== 1'b0 || tp_level !== 3'd0) begin
      miscompares++;
      $display("FAIL tp_no_repeat: ack=%b level=%0d expected 0 0", tp_ack, tp_level);
    end
  endtask

  task automatic test_fp_basic;
    fp_send(8'h5A);
    wait_ack_fp(1'b1, "fp_ack_rise");
    vectors++;
    if (fp_valid !== 1'b1 || fp_level !== 3'd1) begin
      miscompares++;
      $display("FAIL fp_capture: valid=%b level=%0d expected 1 1", fp_valid, fp_level);
    end
    @(negedge clk);
    fp_in = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (fp_ack !== 1'b1) begin
          miscompares++;
          $display("FAIL fp_null_early: ack=%b expected 1", fp_ack);
        end
      end
      if (c == 4) begin
        vectors++;
        if (fp_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL fp_null_fall: ack=%b expected 0", fp_ack);
        end
      end
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (fp_level !== 3'd1 || fp_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_no_dup: level=%0d ack=%b expected 1 0", fp_level, fp_ack);
    end
    drain_fp(1);
  endtask

  task automatic test_fp_back_to_back;
    logic [7:0] w [3] = '{8'hC7, 8'h00, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      fp_send(w[k]);
      wait_ack_fp(1'b1, "fp_b2b_rise");
      @(negedge clk);
      fp_in = '0;
      wait_ack_fp(1'b0, "fp_b2b_fall");
    end
    vectors++;
    if (fp_level !== 3'd3) begin
      miscompares++;
      $display("FAIL fp_b2b_level: level=%0d expected 3", fp_level);
    end
    drain_fp(3);
  endtask

  task automatic test_backpressure;
    for (int k = 1; k <= 4; k++) begin
      tp_send(8'(k));
      wait_ack_tp(k[0], "bp_ack");
    end
    tp_send(8'd5);
    repeat (15) @(negedge clk);
    vectors++;
    if (tp_ack !== 1'b0 || tp_level !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_withheld: ack=%b level=%0d expected 0 4", tp_ack, tp_level);
    end
    drain_tp(1);
    wait_ack_tp(1'b1, "bp_fifth_ack");
    @(negedge clk);
    vectors++;
    if (tp_level !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_level: level=%0d expected 4", tp_level);
    end
    drain_tp(4);
  endtask

  task automatic test_skew;
    logic early;
    early = 1'b0;
    @(negedge clk);
    tp_drive(8'hC3, 8'h07);
    exp_tp.push_back(8'hC3);
    @(negedge clk);
    early = early | (tp_ack !== 1'b1);
    tp_drive(8'hC3, 8'h38);
    @(negedge clk);
    early = early | (tp_ack !== 1'b1);
    tp_drive(8'hC3, 8'hC0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      early = early | (tp_ack !== 1'b1) | (tp_level !== 3'd0);
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL skew_early: ack=%b level=%0d expected ack 1 level 0 throughout", tp_ack, tp_level);
    end
    @(negedge clk);
    vectors++;
    if (tp_ack !== 1'b0 || tp_level !== 3'd1) begin
      miscompares++;
      $display("FAIL skew_capture: ack=%b level=%0d expected 0 1", tp_ack, tp_level);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (tp_level !== 3'd1) begin
      miscompares++;
      $display("FAIL skew_single: level=%0d expected 1", tp_level);
    end
    drain_tp(1);
  endtask

  task automatic test_reset_mid;
    tp_send(8'h11);
    wait_ack_tp(1'b1, "rm_ack1");
    tp_send(8'h22);
    wait_ack_tp(1'b0, "rm_ack2");
    tp_send(8'h33);
    wait_ack_tp(1'b1, "rm_ack3");
    drain_tp(1);
    @(negedge clk);
    tp_drive(8'h44, 8'hFF);
    repeat (3) @(negedge clk);
    vectors++;
    if (tp_level !== 3'd2 || tp_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_pre: level=%0d ack=%b expected 2 1", tp_level, tp_ack);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tp_ack !== 1'b0 || tp_valid !== 1'b0 || tp_level !== 3'd0) begin
      miscompares++;
      $display("FAIL rm_async: ack=%b valid=%b level=%0d expected 0 0 0", tp_ack, tp_valid, tp_level);
    end
    tp_in = '0;
    exp_tp.delete();
    exp_fp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tp_send(8'h96);
    wait_ack_tp(1'b1, "rm_recover_ack");
    drain_tp(1);
  endtask

  task automatic test_fp_illegal;
`ifdef DR_LINK_RX_ERR_CHK_EN
    @(negedge clk);
    fp_in = '0;
    fp_in[3] = 2'b11;
    repeat (3) @(negedge clk);
    fp_in = '0;
    repeat (10) @(negedge clk);
    vectors++;
    if (fp_err !== 1'b1 || fp_level !== 3'd0 || fp_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_err: err=%b level=%0d ack=%b expected 1 0 0", fp_err, fp_level, fp_ack);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (fp_err !== 1'b1 || tp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_sticky: fp err=%b tp err=%b expected 1 0", fp_err, tp_err);
    end
`else
    @(negedge clk);
    for (int i = 0; i < 8; i++) fp_in[i] = 2'b01;
    fp_in[3] = 2'b11;
    exp_fp.push_back(8'h08);
    wait_ack_fp(1'b1, "fp_illegal_ack");
    @(negedge clk);
    fp_in = '0;
    wait_ack_fp(1'b0, "fp_illegal_null");
    drain_fp(1);
    vectors++;
    if (fp_err !== 1'b0 || tp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_tied: fp err=%b tp err=%b expected 0 0", fp_err, tp_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_tp_basic();
    test_fp_basic();
    test_fp_back_to_back();
    test_backpressure();
    test_skew();
    test_reset_mid();
    test_fp_illegal();
    vectors++;
    if (exp_tp.size() != 0 || exp_fp.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: tp %0d fp %0d entries, expected 0 0", exp_tp.size(), exp_fp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
